// File: rtl/score_counter.sv
// Push-button front end for the scoreboard: synchronizes and debounces inc/dec/clr,
// turns presses (plus optional hold auto-repeat) into events and keeps a saturating score.
module score_counter #(
  parameter int SCORE_W         = 7,
  parameter int MAX_SCORE       = 99,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 1000000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               inc_btn_i,
  input  logic               dec_btn_i,
  input  logic               clr_btn_i,
  output logic [SCORE_W-1:0] score_o,
  output logic               max_o,
  output logic               changed_o
);

  localparam int BTN_INC = 0;
  localparam int BTN_DEC = 1;
  localparam int BTN_CLR = 2;

  localparam int DB_W    = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX);

  localparam logic [DB_W-1:0]    DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0]   DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0]   PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = SCORE_W'(MAX_SCORE);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [2:0]         raw;
  logic [2:0]         sync_p0;
  logic [2:0]         sync_p1;
  logic [2:0]         db_p2;
  logic [2:0]         db_d_p2;
  logic [2:0]         rise_p2;
  logic [2:0]         fire_p2;
  logic [2:0]         vld_p3;
  logic [SCORE_W-1:0] score_next;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v < SCORE_MAX) ? v + SCORE_W'(1) : v;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_dec(input logic [SCORE_W-1:0] v);
    return (v != '0) ? v - SCORE_W'(1) : v;
  endfunction

  assign raw = {clr_btn_i, dec_btn_i, inc_btn_i};

  // Stage p0/p1: two-flop synchronizer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: debounced levels; a level change needs DEBOUNCE_CYCLES disagreeing samples in a row
  for (genvar b = 0; b < 3; b++) begin : g_db
    logic [DB_W-1:0] cnt;
    logic            db_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt  <= '0;
        db_q <= 1'b0;
      end else if (sync_p1[b] == db_q) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        db_q <= sync_p1[b];
        cnt  <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end

    assign db_p2[b] = db_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      db_d_p2 <= '0;
    end else begin
      db_d_p2 <= db_p2;
    end
  end

  assign rise_p2 = db_p2 & ~db_d_p2;

  for (genvar b = 0; b < 2; b++) begin : g_rpt
    if (REPEAT_EN) begin : g_on
      logic [1:0]       state;
      logic [RPT_W-1:0] cnt;

      always_ff @(posedge clk_i) begin
        if (rst_i || !db_p2[b]) begin
          state <= ST_IDLE;
          cnt   <= '0;
        end else begin
          case (state)
            ST_IDLE: begin
              if (rise_p2[b]) begin
                state <= ST_DELAY;
                cnt   <= '0;
              end
            end
            ST_DELAY: begin
              if (cnt == DELAY_LAST) begin
                state <= ST_REPEAT;
                cnt   <= '0;
              end else begin
                cnt <= cnt + RPT_W'(1);
              end
            end
            ST_REPEAT: begin
              if (cnt == PERIOD_LAST) begin
                cnt <= '0;
              end else begin
                cnt <= cnt + RPT_W'(1);
              end
            end
            default: begin
              state <= ST_IDLE;
              cnt   <= '0;
            end
          endcase
        end
      end

      assign fire_p2[b] = db_p2[b] &&
                          (((state == ST_DELAY)  && (cnt == DELAY_LAST)) ||
                           ((state == ST_REPEAT) && (cnt == PERIOD_LAST)));
    end else begin : g_off
      assign fire_p2[b] = 1'b0;
    end
  end

  assign fire_p2[BTN_CLR] = 1'b0;

  // Stage p3: registered one-cycle events
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p3 <= '0;
    end else begin
      vld_p3 <= rise_p2 | fire_p2;
    end
  end

  always_comb begin
    score_next = score_o;
    if (vld_p3[BTN_CLR]) begin
      score_next = '0;
    end else if (vld_p3[BTN_INC] && vld_p3[BTN_DEC]) begin
      score_next = score_o;
    end else if (vld_p3[BTN_INC]) begin
      score_next = sat_inc(score_o);
    end else if (vld_p3[BTN_DEC]) begin
      score_next = sat_dec(score_o);
    end
  end

  // Stage p4: score and flags register together
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      score_o   <= '0;
      max_o     <= 1'b0;
      changed_o <= 1'b0;
    end else begin
      score_o   <= score_next;
      max_o     <= (score_next == SCORE_MAX);
      changed_o <= (score_next != score_o);
    end
  end

endmodule

// File: tb/tb_score_counter.sv
// Randomized and directed bench for score_counter against a history-based reference model.
module tb_score_counter;

  localparam int MAXS = 99;
  localparam int DB   = 4;
  localparam int RD   = 20;
  localparam int RP   = 10;

  logic       clk;
  logic       rst;
  logic       inc;
  logic       dec;
  logic       clr;
  logic [6:0] score;
  logic       max_f;
  logic       chg;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int  cyc      = 0;
  int  rst_edge = 0;
  bit  hist [3][64];
  bit  mdb  [3];
  bit  mdb_d[3];
  bit  mev  [3];
  bit  pval [2];
  int  pedge[2];
  int  m_score = 0;
  bit  m_max   = 0;
  bit  m_chg   = 0;

  score_counter #(
    .SCORE_W(7),
    .MAX_SCORE(MAXS),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_EN(1'b1),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .inc_btn_i(inc),
    .dec_btn_i(dec),
    .clr_btn_i(clr),
    .score_o(score),
    .max_o(max_f),
    .changed_o(chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a level is accepted once the last DB synchronized samples all disagree with it;
  // a press starts repeats at +RD then every RP while held; score follows the priority rules.
  task automatic model_step();
    bit raw[3];
    bit db_n[3];
    bit ev_n[3];
    int nw;
    int k;
    int m;
    bit sv;
    bit diff;
    raw[0] = inc; raw[1] = dec; raw[2] = clr;
    if (rst) begin
      rst_edge = cyc;
      for (int b = 0; b < 3; b++) begin
        hist[b][cyc % 64] = 1'b0;
        mdb[b] = 0; mdb_d[b] = 0; mev[b] = 0;
      end
      pval[0] = 0; pval[1] = 0;
      m_score = 0; m_max = 0; m_chg = 0;
    end else begin
      for (int b = 0; b < 3; b++) hist[b][cyc % 64] = raw[b];
      nw = m_score;
      if (mev[2]) nw = 0;
      else if (mev[0] && mev[1]) nw = m_score;
      else if (mev[0]) nw = (m_score < MAXS) ? m_score + 1 : m_score;
      else if (mev[1]) nw = (m_score > 0) ? m_score - 1 : m_score;
      m_chg = (nw != m_score);
      m_score = nw;
      m_max = (nw == MAXS);
      for (int b = 0; b < 3; b++) begin
        ev_n[b] = mdb[b] & ~mdb_d[b];
        if (b < 2) begin
          if (!mdb[b]) pval[b] = 0;
          else if (pval[b]) begin
            k = cyc - pedge[b];
            if (k == RD || (k > RD && (k - RD) % RP == 0)) ev_n[b] = 1;
          end
          if (mdb[b] && !mdb_d[b]) begin
            pval[b] = 1;
            pedge[b] = cyc;
          end
        end
        diff = 1;
        for (int j = 0; j < DB; j++) begin
          m = cyc - j;
          sv = (m - 2 > rst_edge) ? hist[b][(m - 2) % 64] : 1'b0;
          if (sv == mdb[b]) diff = 0;
        end
        db_n[b] = diff ? ~mdb[b] : mdb[b];
      end
      for (int b = 0; b < 3; b++) begin
        mdb_d[b] = mdb[b];
        mdb[b] = db_n[b];
        mev[b] = ev_n[b];
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1; inc = 0; dec = 0; clr = 0;
    tick(); tick();
    rst = 0;
    tick();
  endtask

  task automatic press(input bit pi, input bit pd, input bit pc, input int hold, input int gap,
                       output int pulses);
    pulses = 0;
    inc = pi; dec = pd; clr = pc;
    repeat (hold) begin tick(); if (chg === 1'b1) pulses++; end
    inc = 0; dec = 0; clr = 0;
    repeat (gap) begin tick(); if (chg === 1'b1) pulses++; end
  endtask

  task automatic test_reset();
    rst = 1; inc = 0; dec = 0; clr = 0;
    repeat (3) tick();
    n_checks++;
    if ({score, max_f, chg} !== 9'd0) begin
      n_fail++; $display("FAIL reset_hold: got score=%0d max=%0b chg=%0b, expected all 0", score, max_f, chg);
    end
    rst = 0;
    repeat (6) tick();
    n_checks++;
    if ({score, max_f, chg} !== 9'd0) begin
      n_fail++; $display("FAIL reset_release: got score=%0d max=%0b chg=%0b, expected all 0", score, max_f, chg);
    end
    inc = 1;
    for (int i = 0; i < 700 && m_score != 42; i++) begin
      tick();
      n_checks++;
      if ({score, max_f, chg} !== {7'(m_score), m_max, m_chg}) begin
        n_fail++; $display("FAIL climb_cycle: got score=%0d max=%0b chg=%0b, expected %0d/%0b/%0b", score, max_f, chg, m_score, m_max, m_chg);
      end
    end
    n_checks++;
    if (score !== 7'd42) begin
      n_fail++; $display("FAIL climb_42: got %0d expected 42", score);
    end
    rst = 1;
    tick();
    rst = 0;
    n_checks++;
    if ({score, max_f, chg} !== 9'd0) begin
      n_fail++; $display("FAIL reset_mid_count: got score=%0d max=%0b chg=%0b, expected all 0", score, max_f, chg);
    end
    repeat (12) begin
      tick();
      n_checks++;
      if ({score, max_f, chg} !== {7'(m_score), m_max, m_chg}) begin
        n_fail++; $display("FAIL held_over_reset: got score=%0d chg=%0b, expected %0d/%0b", score, chg, m_score, m_chg);
      end
    end
    n_checks++;
    if (score !== 7'd1) begin
      n_fail++; $display("FAIL held_redebounce: got %0d expected 1", score);
    end
    inc = 0;
    repeat (15) tick();
  endtask

  task automatic test_debounce_latency();
    int pulses;
    int p;
    apply_reset();
    pulses = 0;
    inc = 1;
    for (int i = 1; i <= 32; i++) begin
      if (i == 21) inc = 0;
      tick();
      if (chg === 1'b1) pulses++;
      n_checks++;
      if ({score, max_f, chg} !== {7'(m_score), m_max, m_chg}) begin
        n_fail++; $display("FAIL latency_cycle%0d: got score=%0d chg=%0b, expected %0d/%0b", i, score, chg, m_score, m_chg);
      end
      if (i == 7) begin
        n_checks++;
        if (score !== 7'd0) begin
          n_fail++; $display("FAIL latency_early: got %0d at t+6 expected 0", score);
        end
      end
      if (i == 8) begin
        n_checks++;
        if ({score, chg} !== {7'd1, 1'b1}) begin
          n_fail++; $display("FAIL latency_edge: got score=%0d chg=%0b at t+7, expected 1/1", score, chg);
        end
      end
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++; $display("FAIL single_pulse: got %0d pulses expected 1", pulses);
    end
    press(1, 0, 0, 20, 12, p);
    press(1, 0, 0, 20, 12, p);
    n_checks++;
    if (score !== 7'd3) begin
      n_fail++; $display("FAIL three_presses: got %0d expected 3", score);
    end
  endtask

  task automatic test_glitch();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      inc = (i < 3 || (i >= 4 && i < 7)) ? 1'b1 : 1'b0;
      tick();
      if (chg === 1'b1) pulses++;
      n_checks++;
      if ({score, chg} !== {7'(m_score), m_chg}) begin
        n_fail++; $display("FAIL glitch_cycle%0d: got score=%0d chg=%0b, expected %0d/%0b", i, score, chg, m_score, m_chg);
      end
    end
    n_checks++;
    if (pulses !== 0 || score !== 7'd3) begin
      n_fail++; $display("FAIL glitch_reject: got score=%0d pulses=%0d, expected 3/0", score, pulses);
    end
  endtask

  task automatic test_saturation();
    int p;
    press(0, 0, 1, 6, 10, p);
    for (int i = 0; i < 98; i++) press(1, 0, 0, 6, 10, p);
    n_checks++;
    if ({score, max_f} !== {7'd98, 1'b0}) begin
      n_fail++; $display("FAIL preload_98: got score=%0d max=%0b, expected 98/0", score, max_f);
    end
    press(1, 0, 0, 6, 10, p);
    n_checks++;
    if ({score, max_f} !== {7'd99, 1'b1} || p !== 1) begin
      n_fail++; $display("FAIL reach_max: got score=%0d max=%0b pulses=%0d, expected 99/1/1", score, max_f, p);
    end
    press(1, 0, 0, 6, 10, p);
    n_checks++;
    if ({score, max_f} !== {7'd99, 1'b1} || p !== 0) begin
      n_fail++; $display("FAIL hold_max: got score=%0d max=%0b pulses=%0d, expected 99/1/0", score, max_f, p);
    end
    press(0, 0, 1, 6, 10, p);
    n_checks++;
    if ({score, max_f} !== {7'd0, 1'b0} || p !== 1) begin
      n_fail++; $display("FAIL clear_from_max: got score=%0d max=%0b pulses=%0d, expected 0/0/1", score, max_f, p);
    end
    press(0, 1, 0, 6, 10, p);
    n_checks++;
    if (score !== 7'd0 || p !== 0) begin
      n_fail++; $display("FAIL dec_at_zero: got score=%0d pulses=%0d, expected 0/0", score, p);
    end
    press(0, 0, 1, 6, 10, p);
    n_checks++;
    if (score !== 7'd0 || p !== 0) begin
      n_fail++; $display("FAIL clear_at_zero: got score=%0d pulses=%0d, expected 0/0", score, p);
    end
  endtask

  task automatic test_repeat();
    int pulses;
    pulses = 0;
    inc = 1;
    for (int i = 0; i < 68; i++) begin
      if (i == 48) inc = 0;
      tick();
      if (chg === 1'b1) pulses++;
      n_checks++;
      if ({score, max_f, chg} !== {7'(m_score), m_max, m_chg}) begin
        n_fail++; $display("FAIL repeat_cycle%0d: got score=%0d chg=%0b, expected %0d/%0b", i, score, chg, m_score, m_chg);
      end
    end
    n_checks++;
    if (score !== 7'd4 || pulses !== 4) begin
      n_fail++; $display("FAIL repeat_total: got score=%0d pulses=%0d, expected 4/4", score, pulses);
    end
  endtask

  task automatic test_priority();
    int p;
    for (int i = 0; i < 6; i++) press(1, 0, 0, 6, 10, p);
    n_checks++;
    if (score !== 7'd10) begin
      n_fail++; $display("FAIL preload_10: got %0d expected 10", score);
    end
    press(1, 0, 1, 6, 10, p);
    n_checks++;
    if (score !== 7'd0 || p !== 1) begin
      n_fail++; $display("FAIL clr_over_inc: got score=%0d pulses=%0d, expected 0/1", score, p);
    end
    for (int i = 0; i < 5; i++) press(1, 0, 0, 6, 10, p);
    press(1, 1, 0, 6, 10, p);
    n_checks++;
    if (score !== 7'd5 || p !== 0) begin
      n_fail++; $display("FAIL inc_dec_cancel: got score=%0d pulses=%0d, expected 5/0", score, p);
    end
  endtask

  task automatic test_random();
    int cycles;
    int len;
    cycles = 0;
    while (cycles < 1500) begin
      len = $urandom_range(14, 1);
      inc = 1'($urandom_range(1, 0));
      dec = 1'($urandom_range(1, 0));
      clr = ($urandom_range(7, 0) == 0);
      rst = ($urandom_range(40, 0) == 0);
      for (int i = 0; i < len; i++) begin
        tick();
        rst = 0;
        cycles++;
        n_checks++;
        if ({score, max_f, chg} !== {7'(m_score), m_max, m_chg}) begin
          n_fail++; $display("FAIL rand_cycle%0d: got score=%0d max=%0b chg=%0b, expected %0d/%0b/%0b", cycles, score, max_f, chg, m_score, m_max, m_chg);
        end
      end
    end
    inc = 0; dec = 0; clr = 0; rst = 0;
    repeat (10) tick();
  endtask

  initial begin
    rst = 1; inc = 0; dec = 0; clr = 0;
    test_reset();
    test_debounce_latency();
    test_glitch();
    test_saturation();
    test_repeat();
    test_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_counter.md
Name: score_counter

Overview:
Upstream feeder of the scoreboard's binary-to-decimal stage. It synchronizes and debounces three raw push-buttons (increment, decrement, clear) and turns presses into single events, with optional auto-repeat on hold. It maintains a saturating score in the range 0..MAX_SCORE and drives the 7-bit binary score consumed by the tens/ones converter.

Parameters:
SCORE_W, 7, score width; must match the converter input.
MAX_SCORE, 99, upper saturation limit; must satisfy MAX_SCORE < 2**SCORE_W.
DEBOUNCE_CYCLES, 50000, consecutive stable synchronized samples required to accept a level change; minimum 1.
REPEAT_EN, 1, 1 enables hold auto-repeat on inc/dec; 0 gives exactly one event per press.
REPEAT_DELAY, 5000000, cycles from the initial press event to the first repeat event.
REPEAT_PERIOD, 1000000, cycles between subsequent repeat events.

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset; synchronous, active-high
inc_btn_i  input  1  raw increment button, asynchronous, active-high
dec_btn_i  input  1  raw decrement button, asynchronous, active-high
clr_btn_i  input  1  raw clear button, asynchronous, active-high
score_o  output  SCORE_W  current score, binary, registered
max_o  output  1  registered; high when score_o == MAX_SCORE
changed_o  output  1  one-cycle pulse on the cycle score_o takes a new value

Behaviour:
- Reset: single clock, clk_i. Reset is synchronous and active-high on rst_i.
  - On reset, score_o=0, max_o=0, changed_o=0.
  - Synchronizer flops, debounced levels, debounce counters, repeat FSMs and repeat counters all go to 0/IDLE.
  - Reset asserted mid-press or mid-repeat aborts immediately.
  - A button still held when reset is released counts as a fresh press only after it has been debounced again.
- Synchronizer: two flops per button. Their output is s.
- Debounce, per button:
  - If s == db, the counter clears.
  - Otherwise the counter increments. When s has differed from db for DEBOUNCE_CYCLES consecutive cycles, db <= s and the counter clears.
  - Any single disagreeing sample restarts the count.
- Press event: a db rising edge gives a one-cycle event. Falling edges produce nothing.
- Latency: a raw input rising and staying stable from edge t produces its first score_o change at edge t+DEBOUNCE_CYCLES+3.
- Repeat FSM, per inc/dec button, only when REPEAT_EN=1:
  - IDLE -> DELAY on the press event; the counter is cleared.
  - In DELAY, when the counter reaches REPEAT_DELAY-1, emit an event, go to REPEAT and clear the counter.
  - In REPEAT, when the counter reaches REPEAT_PERIOD-1, emit an event and clear the counter.
  - From any state, db low -> IDLE on the next edge, with no event emitted.
  - clr has no repeat.
- Score update, evaluated each cycle from that cycle's events, in priority order:
  1. clr event -> score 0, regardless of inc/dec.
  2. inc and dec both present -> no change.
  3. inc -> score+1 if score < MAX_SCORE, else hold.
  4. dec -> score-1 if score > 0, else hold.
- Arithmetic: saturating only. Never wraps (no 0->127, no 99->100).
- changed_o: asserted in the same cycle score_o shows the new value, and only if the value actually differed. Saturated presses and clear-at-zero give no pulse.
- max_o: updated together with score_o.

Test Plan:
1. Reset, then release with all buttons low -> score_o=0, max_o=0, changed_o=0. Hold rst_i high for 1 cycle mid-count at score 42 -> score_o=0 on the next edge.
2. DEBOUNCE_CYCLES=4, REPEAT_EN=0; inc held high from edge t for 20 cycles -> score_o 0->1 at edge t+7, exactly one changed_o pulse. Total after 3 such presses: 3.
3. DEBOUNCE_CYCLES=4; inc pulses high 3 cycles, low 1, high 3, low -> score_o stays 0, no changed_o.
4. Preload to 98 via presses; inc twice -> 99 then holds at 99, max_o=1, second press gives no changed_o. From 0, dec press -> stays 0, no pulse. Clear at 0 -> no pulse.
5. DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=10; inc held until 45 cycles after the first event -> events at +0, +20, +30, +40, score 0->4. Release -> no further events.
6. Score 10; inc and clr debounced to rise on the same cycle -> score_o=0, one changed_o pulse. Then inc and dec simultaneous at score 5 -> stays 5, no pulse.
